// File: rtl/cl_serial_pkg.sv
// Shared types and constants for the CameraLink serial command controller.
// Optional CL_CMD_AUTO_TERM_EN build is handled in cl_serial_cmd_ctrl.sv.
package cl_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_START,
    TX_WAIT_HI,
    TX_WAIT_LO,
    RX_WAIT,
    DONE
  } state_t;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/cl_serial_cmd_ctrl_if.sv
// UART-side handshake bundle between the command controller (master) and the UART (slave).
interface cl_serial_cmd_ctrl_if;

  logic       uart_tx_start;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;
  logic       uart_rx_ready;
  logic [7:0] uart_rx_data;

  modport master (
    output uart_tx_start,
    output uart_tx_data,
    input  uart_tx_busy,
    input  uart_rx_ready,
    input  uart_rx_data
  );

  modport slave (
    input  uart_tx_start,
    input  uart_tx_data,
    output uart_tx_busy,
    output uart_rx_ready,
    output uart_rx_data
  );

endinterface

// File: rtl/cl_byte_buf.sv
// Byte buffer: one write port, registered read port (1-cycle latency, write-first on address match).
module cl_byte_buf #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Bypass lets a byte written and read in the same cycle come out fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      rdata <= '0;
    else if (we && (waddr == raddr)) rdata <= wdata;
    else                             rdata <= mem[raddr];
  end

endmodule

// File: rtl/cl_serial_cmd_ctrl.sv
// CameraLink serial command/response sequencer: sends a buffered command over the UART, collects the reply.
// Build option CL_CMD_AUTO_TERM_EN appends TERM_CHAR after the last command byte.
module cl_serial_cmd_ctrl
  import cl_serial_pkg::*;
#(
  parameter int unsigned CMD_DEPTH      = 16,
  parameter int unsigned RSP_DEPTH      = 16,
  parameter logic [7:0]  TERM_CHAR      = CHAR_CR,
  parameter int unsigned TIMEOUT_CYCLES = 12500000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_wr_en,
  input  logic [7:0]                   cmd_wr_data,
  output logic                         cmd_full,
  input  logic                         cmd_go,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic                         rsp_overflow,
  output logic [$clog2(RSP_DEPTH):0]   rsp_len,
  input  logic [$clog2(RSP_DEPTH)-1:0] rsp_rd_addr,
  output logic [7:0]                   rsp_rd_data,
  cl_serial_cmd_ctrl_if.master         uart
);

  localparam int unsigned CAW = $clog2(CMD_DEPTH);
  localparam int unsigned CCW = CAW + 1;
  localparam int unsigned RAW = $clog2(RSP_DEPTH);
  localparam int unsigned RLW = RAW + 1;

  state_t           state;
  logic [CCW-1:0]   cmd_cnt;
  logic [CAW-1:0]   idx;
  logic [31:0]      tmo_cnt;
  logic             rx_prev;
  logic [7:0]       cmd_rdata;

  logic             cmd_we_c;
  logic [CCW-1:0]   cmd_cnt_new_c;
  logic [CAW-1:0]   cmd_raddr_c;
  logic             last_byte_c;
  logic             rx_evt_c;
  logic             rsp_we_c;
  logic [7:0]       tx_byte_c;
  logic             tx_last_c;

  assign cmd_full      = (cmd_cnt == CCW'(CMD_DEPTH));
  assign cmd_we_c      = cmd_wr_en && (state == IDLE) && !cmd_full;
  assign cmd_cnt_new_c = cmd_cnt + CCW'(cmd_we_c);
  assign last_byte_c   = (CCW'(idx) == (cmd_cnt - CCW'(1)));

  // Pre-address the next byte while the UART drains so it is ready in TX_START.
  assign cmd_raddr_c = (state == TX_WAIT_LO) ? (idx + CAW'(1)) : idx;

  assign rx_evt_c = uart.uart_rx_ready && !rx_prev;
  assign rsp_we_c = (state == RX_WAIT) && rx_evt_c && (uart.uart_rx_data != TERM_CHAR)
                    && (rsp_len < RLW'(RSP_DEPTH));

`ifdef CL_CMD_AUTO_TERM_EN
  logic term_phase;

  assign tx_byte_c = term_phase ? TERM_CHAR : cmd_rdata;
  assign tx_last_c = term_phase;

  // One extra terminator byte follows the last buffered byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      term_phase <= 1'b0;
    else if ((state == TX_WAIT_LO) && !uart.uart_tx_busy)
      term_phase <= last_byte_c && !term_phase;
  end
`else
  assign tx_byte_c = cmd_rdata;
  assign tx_last_c = last_byte_c;
`endif

  cl_byte_buf #(.DEPTH(CMD_DEPTH)) u_cmd_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cmd_we_c),
    .waddr (cmd_cnt[CAW-1:0]),
    .wdata (cmd_wr_data),
    .raddr (cmd_raddr_c),
    .rdata (cmd_rdata)
  );

  cl_byte_buf #(.DEPTH(RSP_DEPTH)) u_rsp_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rsp_we_c),
    .waddr (rsp_len[RAW-1:0]),
    .wdata (uart.uart_rx_data),
    .raddr (rsp_rd_addr),
    .rdata (rsp_rd_data)
  );

  // Transaction sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cmd_cnt            <= '0;
      idx                <= '0;
      tmo_cnt            <= '0;
      rx_prev            <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      timeout            <= 1'b0;
      rsp_overflow       <= 1'b0;
      rsp_len            <= '0;
      uart.uart_tx_start <= 1'b0;
      uart.uart_tx_data  <= '0;
    end else begin
      rx_prev            <= uart.uart_rx_ready;
      done               <= 1'b0;
      uart.uart_tx_start <= 1'b0;
      if (cmd_we_c) cmd_cnt <= cmd_cnt + CCW'(1);

      case (state)
        IDLE: begin
          if (cmd_go) begin
            busy    <= 1'b1;
            rsp_len <= '0;
            timeout <= 1'b0;
            idx     <= '0;
            if (cmd_cnt_new_c == '0) begin
              state <= DONE;
            end else begin
              rsp_overflow <= 1'b0;
              state        <= TX_START;
            end
          end
        end

        TX_START: begin
          uart.uart_tx_data  <= tx_byte_c;
          uart.uart_tx_start <= 1'b1;
          state              <= TX_WAIT_HI;
        end

        TX_WAIT_HI: begin
          if (uart.uart_tx_busy) state <= TX_WAIT_LO;
        end

        TX_WAIT_LO: begin
          if (!uart.uart_tx_busy) begin
            if (tx_last_c) begin
              cmd_cnt <= '0;
              idx     <= '0;
              tmo_cnt <= 32'(TIMEOUT_CYCLES);
              state   <= RX_WAIT;
            end else begin
              idx   <= idx + CAW'(1);
              state <= TX_START;
            end
          end
        end

        RX_WAIT: begin
          // A byte event beats a coincident timeout expiry.
          if (rx_evt_c) begin
            tmo_cnt <= 32'(TIMEOUT_CYCLES);
            if (uart.uart_rx_data == TERM_CHAR)   state        <= DONE;
            else if (rsp_len < RLW'(RSP_DEPTH))   rsp_len      <= rsp_len + RLW'(1);
            else                                  rsp_overflow <= 1'b1;
          end else if (tmo_cnt <= 32'd1) begin
            tmo_cnt <= '0;
            timeout <= 1'b1;
            state   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 32'd1;
          end
        end

        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cl_serial_cmd_ctrl.sv
// Scoreboard bench for cl_serial_cmd_ctrl with a simple UART model; honours CL_CMD_AUTO_TERM_EN.
module tb_cl_serial_cmd_ctrl;

  localparam int unsigned CMD_DEPTH = 16;
  localparam int unsigned RSP_DEPTH = 16;
  localparam int unsigned TMO       = 1000;
  localparam int unsigned RAW       = $clog2(RSP_DEPTH);
`ifdef CL_CMD_AUTO_TERM_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct {
    int len;
    int tmo;
    int ovf;
  } done_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cmd_wr_en;
  logic [7:0]     cmd_wr_data;
  logic           cmd_full;
  logic           cmd_go;
  logic           busy;
  logic           done;
  logic           timeout;
  logic           rsp_overflow;
  logic [RAW:0]   rsp_len;
  logic [RAW-1:0] rsp_rd_addr;
  logic [7:0]     rsp_rd_data;

  cl_serial_cmd_ctrl_if u_if ();

  cl_serial_cmd_ctrl #(
    .CMD_DEPTH      (CMD_DEPTH),
    .RSP_DEPTH      (RSP_DEPTH),
    .TERM_CHAR      (8'h0D),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_wr_en    (cmd_wr_en),
    .cmd_wr_data  (cmd_wr_data),
    .cmd_full     (cmd_full),
    .cmd_go       (cmd_go),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .rsp_overflow (rsp_overflow),
    .rsp_len      (rsp_len),
    .rsp_rd_addr  (rsp_rd_addr),
    .rsp_rd_data  (rsp_rd_data),
    .uart         (u_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tx_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int lo_cyc = 0;
  int go_cyc = 0;
  int tx_left = 0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;

  logic [7:0] exp_tx_q [$];
  logic [7:0] exp_rd_q [$];
  done_t      exp_done_q [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= rd_req;
  end

  // UART model: busy rises half a cycle after tx_start and lasts four cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_left = 0;
      u_if.uart_tx_busy = 1'b0;
    end else if (tx_left > 0) begin
      tx_left--;
      if (tx_left == 0) begin
        u_if.uart_tx_busy = 1'b0;
        lo_cyc = cyc;
      end
    end else if (u_if.uart_tx_start) begin
      u_if.uart_tx_busy = 1'b1;
      tx_left = 4;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a byte, a done pulse or read data.
  always @(negedge clk) begin
    done_t e;
    if (rst_n && u_if.uart_tx_start) begin
      tx_cnt++;
      if (exp_tx_q.size() == 0) check("unexpected_tx_start", int'(u_if.uart_tx_start), 0);
      else check("tx_data", int'(u_if.uart_tx_data), int'(exp_tx_q.pop_front()));
    end
    if (rst_n && done) begin
      done_cnt++;
      done_cyc = cyc;
      if (exp_done_q.size() == 0) check("unexpected_done", int'(done), 0);
      else begin
        e = exp_done_q.pop_front();
        check("done_rsp_len", int'(rsp_len), e.len);
        check("done_timeout", int'(timeout), e.tmo);
        check("done_overflow", int'(rsp_overflow), e.ovf);
      end
    end
    if (rd_vld && exp_rd_q.size() != 0)
      check("rsp_rd_data", int'(rsp_rd_data), int'(exp_rd_q.pop_front()));
  end

  task automatic wr(input logic [7:0] b);
    cmd_wr_en = 1'b1;
    cmd_wr_data = b;
    @(negedge clk);
    cmd_wr_en = 1'b0;
  endtask

  task automatic go();
    cmd_go = 1'b1;
    go_cyc = cyc;
    @(negedge clk);
    cmd_go = 1'b0;
  endtask

  task automatic exp_tx(input logic [7:0] b);
    exp_tx_q.push_back(b);
  endtask

  task automatic exp_term();
    if (AUTO) exp_tx_q.push_back(8'h0D);
  endtask

  task automatic exp_done(input int len, input int tmo, input int ovf);
    done_t e;
    e.len = len;
    e.tmo = tmo;
    e.ovf = ovf;
    exp_done_q.push_back(e);
  endtask

  task automatic rd(input int a, input logic [7:0] exp);
    rsp_rd_addr = RAW'(a);
    rd_req = 1'b1;
    exp_rd_q.push_back(exp);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input int hold);
    u_if.uart_rx_data = b;
    u_if.uart_rx_ready = 1'b1;
    repeat (hold) @(negedge clk);
    u_if.uart_rx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tx_idle(input int target);
    int n = 0;
    while (!(tx_cnt >= target && !u_if.uart_tx_busy) && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) check("wait_tx_idle", tx_cnt, target);
    @(negedge clk);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) check("wait_done", done_cnt, target);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
    check({tag, "_overflow"}, int'(rsp_overflow), 0);
    check({tag, "_rsp_len"}, int'(rsp_len), 0);
    check({tag, "_rd_data"}, int'(rsp_rd_data), 0);
    check({tag, "_cmd_full"}, int'(cmd_full), 0);
    check({tag, "_tx_start"}, int'(u_if.uart_tx_start), 0);
    check({tag, "_tx_data"}, int'(u_if.uart_tx_data), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    cmd_wr_en = 1'b0;
    cmd_wr_data = '0;
    cmd_go = 1'b0;
    rsp_rd_addr = '0;
    u_if.uart_rx_ready = 1'b0;
    u_if.uart_rx_data = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // "ID?" -> "CAM1" CR; first reply byte held high five cycles counts once.
    wr(8'h49); wr(8'h44); wr(8'h3F);
    exp_tx(8'h49); exp_tx(8'h44); exp_tx(8'h3F); exp_term();
    exp_done(4, 0, 0);
    t = tx_cnt + 3 + int'(AUTO);
    go();
    wait_tx_idle(t);
    send_rx(8'h43, 5); send_rx(8'h41, 1); send_rx(8'h4D, 1); send_rx(8'h31, 1);
    send_rx(8'h0D, 1);
    wait_done(1, 100);
    rd(0, 8'h43); rd(1, 8'h41); rd(2, 8'h4D); rd(3, 8'h31);

    // No reply: RX_WAIT lasts TMO cycles, timeout one edge later, done the edge after.
    wr(8'h55);
    exp_tx(8'h55); exp_term();
    exp_done(0, 1, 0);
    t = tx_cnt + 1 + int'(AUTO);
    go();
    wait_tx_idle(t);
    wait_done(2, TMO + 100);
    check("timeout_latency", done_cyc - lo_cyc, TMO + 2);

    // 20 reply bytes into a 16-byte buffer.
    wr(8'h56);
    exp_tx(8'h56); exp_term();
    exp_done(16, 0, 1);
    t = tx_cnt + 1 + int'(AUTO);
    go();
    wait_tx_idle(t);
    for (int i = 0; i < 20; i++) send_rx(8'h60 + 8'(i), 1);
    send_rx(8'h0D, 1);
    wait_done(3, 100);
    rd(0, 8'h60); rd(7, 8'h67); rd(15, 8'h6F);

    // Fill the command buffer, overfill by one, write while busy.
    for (int i = 0; i < 17; i++) begin
      wr(8'hA0 + 8'(i));
      if (i == 14) check("cmd_full_at_15", int'(cmd_full), 0);
      if (i == 15) check("cmd_full_at_16", int'(cmd_full), 1);
    end
    check("cmd_full_after_17", int'(cmd_full), 1);
    for (int i = 0; i < 16; i++) exp_tx(8'hA0 + 8'(i));
    exp_term();
    exp_done(0, 0, 0);
    t = tx_cnt + 16 + int'(AUTO);
    go();
    check("busy_in_tx", int'(busy), 1);
    wr(8'hEE);
    wait_tx_idle(t);
    check("cmd_full_cleared", int'(cmd_full), 0);
    send_rx(8'h0D, 1);
    wait_done(4, 100);

    // Idle-time byte is discarded; empty go completes in two cycles with no TX.
    send_rx(8'h77, 1);
    exp_done(0, 0, 0);
    go();
    wait_done(5, 20);
    check("empty_go_latency", done_cyc - go_cyc, 2);
    check("busy_after_empty", int'(busy), 0);

    // Reset in the middle of the first byte's UART busy period.
    wr(8'h41); wr(8'h42);
    exp_tx(8'h41);
    t = tx_cnt + 1;
    go();
    begin
      int n = 0;
      while (!(tx_cnt >= t && u_if.uart_tx_busy) && n < 50) begin
        @(posedge clk);
        n++;
      end
      if (n >= 50) check("wait_tx_busy", tx_cnt, t);
    end
    @(negedge clk);
    check("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("done_cnt_after_reset", done_cnt, 5);

    // Normal transaction after reset.
    wr(8'h31); wr(8'h32);
    exp_tx(8'h31); exp_tx(8'h32); exp_term();
    exp_done(1, 0, 0);
    t = tx_cnt + 2 + int'(AUTO);
    go();
    wait_tx_idle(t);
    send_rx(8'h5A, 1);
    send_rx(8'h0D, 1);
    wait_done(6, 100);
    rd(0, 8'h5A);

    repeat (5) @(negedge clk);
    check("tx_queue_left", exp_tx_q.size(), 0);
    check("done_queue_left", exp_done_q.size(), 0);
    check("rd_queue_left", exp_rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
